// File: rtl/uart_tx_cfg_if.sv
// Input word stream into the configurable UART transmitter: a plain valid/ready push port.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small TX FIFO feeding a frame serializer with
// runtime baud divisor, parity mode and stop-bit count latched per frame.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  uart_tx_cfg_if.slave                     in_if,
  input  logic [DIV_W-1:0]                 cfg_baud_div,
  input  logic [1:0]                       cfg_parity,
  input  logic                             cfg_stop2,
  output logic                             tx,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  assign in_if.in_ready = (level_q != LVL_W'(FIFO_DEPTH));
  // Full refuses the push even when a pop frees a slot this cycle.
  assign push = in_if.in_valid & in_if.in_ready;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_data;
  end

  // ---------------- serializer ----------------
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q;
  logic              par_en_q, par_bit_q, stop2_q;
  logic              tx_q, tx_d;
  logic              busy_q, done_q, done_d;
  logic              load;
  logic              period_end;

  // Divisor 0 and 1 both give a one-clock bit period.
  assign period_end = (div_q <= DIV_W'(1)) || (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = period_end ? '0 : cnt_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    load    = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) load = 1'b1;
      end
      START: begin
        tx_d = 1'b0;
        if (period_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (period_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (period_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (period_end) begin
          if (!stop2_q || bit_q != '0) begin
            done_d = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (level_q != '0) load = 1'b1;
            else               state_d = IDLE;
          end else begin
            bit_d = BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = head;
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      if (load) begin
        div_q     <= cfg_baud_div;
        par_en_q  <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
        par_bit_q <= (cfg_parity == 2'd2) ? ~^head : ^head;
        stop2_q   <= cfg_stop2;
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg: a line monitor rebuilds each expected frame
// from the accepted word queue and the cfg seen at pop time.
module tb_uart_tx_cfg;
  localparam int DATA_W     = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [1:0]       par;
    logic             stop2;
  } cfg_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_par;
  logic             cfg_stop2;
  logic             tx, busy, done;
  logic [2:0]       fifo_level;

  uart_tx_cfg_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (bus),
    .cfg_baud_div (cfg_div),
    .cfg_parity   (cfg_par),
    .cfg_stop2    (cfg_stop2),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  logic [DATA_W-1:0] exp_q[$];
  cfg_t h0, h1, h2;
  bit   mon_busy = 1'b0;

  task automatic nstep();
    @(negedge clk);
    h2 = h1;
    h1 = h0;
    h0 = {cfg_div, cfg_par, cfg_stop2};
    if (rst_n === 1'b1 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
      exp_q.push_back(bus.in_data);
  endtask

  // Called on the first sample with tx low; cfg was sampled at the edge before the fall.
  task automatic run_frame();
    cfg_t              c;
    int                d, nbits, ones;
    logic [DATA_W-1:0] w;
    logic              bits[$];
    c = h2;
    if (exp_q.size() == 0) begin
      chk("unexpected_frame", 1, 0);
      return;
    end
    w = exp_q.pop_front();
    d = (c.div == 0) ? 1 : int'(c.div);
    ones = $countones(w);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
    if (c.par == 2'd1) bits.push_back(ones % 2 == 1);
    if (c.par == 2'd2) bits.push_back(ones % 2 == 0);
    bits.push_back(1'b1);
    if (c.stop2) bits.push_back(1'b1);
    nbits = bits.size();
    mon_busy = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < d; k++) begin
        if (b != 0 || k != 0) begin
          nstep();
          if (rst_n !== 1'b1) begin
            mon_busy = 1'b0;
            return;
          end
        end
        chk("tx_bit", tx, bits[b]);
        chk("frame_done", done, (b == nbits - 1 && k == d - 1));
        if (!(b == nbits - 1 && k == d - 1)) chk("frame_busy", busy, 1);
      end
    end
    mon_busy = 1'b0;
  endtask

  initial begin
    forever begin
      nstep();
      if (rst_n === 1'b1) begin
        if (tx === 1'b0) run_frame();
        else             chk("idle_done", done, 0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && g < 2000) begin
      tick();
      g++;
    end
    chk("push_timeout", (g < 2000), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || busy) && n < 4000) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < 4000), 1);
    tick();
    tick();
  endtask

  task automatic set_cfg(input int d, input int p, input bit s2);
    cfg_div   = DIV_W'(d);
    cfg_par   = 2'(p);
    cfg_stop2 = s2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int dt[$];
    int cyc;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    set_cfg(4, 0, 1'b0);
    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    tick();

    // Latency: push at edge t, pop at t+1, tx low after t+2.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    chk("lat_level_t", fifo_level, 1);
    chk("lat_busy_t", busy, 0);
    chk("lat_tx_t", tx, 1);
    tick();
    chk("lat_level_t1", fifo_level, 0);
    chk("lat_busy_t1", busy, 1);
    chk("lat_tx_t1", tx, 1);
    tick();
    chk("lat_tx_t2", tx, 0);
    wait_idle();

    set_cfg(4, 1, 1'b0); push_word(8'hA5); wait_idle();
    set_cfg(4, 2, 1'b0); push_word(8'hA5); wait_idle();
    set_cfg(4, 3, 1'b0); push_word(8'h3C); wait_idle();
    set_cfg(3, 0, 1'b1); push_word(8'h00); wait_idle();

    // Burst while the line is busy: one word popped plus a full FIFO.
    set_cfg(2, 0, 1'b0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'($urandom);
      acc += int'(bus.in_ready);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("burst_accepted", acc, 5);
    chk("burst_ready", bus.in_ready, 0);
    chk("burst_level", fifo_level, FIFO_DEPTH);
    cyc = 0;
    while (dt.size() < 5 && cyc < 500) begin
      if (done) dt.push_back(cyc);
      tick();
      cyc++;
    end
    chk("burst_done_count", dt.size(), 5);
    for (int i = 1; i < dt.size(); i++) chk("burst_done_gap", dt[i] - dt[i-1], 20);
    wait_idle();

    // Divisor change mid-frame only affects the following frame.
    set_cfg(4, 0, 1'b0);
    push_word(8'h96);
    repeat (6) tick();
    cfg_div = 16'd8;
    push_word(8'h5A);
    wait_idle();

    set_cfg(0, 1, 1'b1); push_word(8'hC3); push_word(8'h01); wait_idle();

    for (int it = 0; it < 20; it++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) push_word(DATA_W'($urandom));
      wait_idle();
    end

    // Reset in the middle of the data bits with a word still queued.
    set_cfg(4, 0, 1'b0);
    push_word(8'hFF);
    push_word(8'h0F);
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", bus.in_ready, 1);
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_tx", tx, 1);
      chk("postrst_done", done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
